// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serial loader and ones-count verifier for a configuration chain
//
// Purpose: accepts WORD_W-bit configuration words over a valid/ready handshake and
// shifts them LSB-first into the configuration chain, one bit per enabled prog_clk
// edge. An optional verify pass recirculates ccff_tail into ccff_head for CHAIN_LEN
// edges. The pass compares the ones-count read back with the ones-count loaded.
//
// Ports:
//   prog_clk        configuration clock, rising edge
//   prog_reset_n    synchronous active-low reset
//   start           begin a load (sampled in IDLE only)
//   verify_en       sampled with start; request a verify pass after the load
//   word_in         configuration word, bit 0 shifted first
//   word_valid      word_in valid
//   word_ready      loader accepts word_in this cycle
//   ccff_head       serial data into the chain
//   ccff_tail       serial data out of the chain's last flop
//   ccff_shift_en   chain clock enable; the chain shifts on every edge where it is 1
//   busy            high in LOAD or VERIFY
//   done            one-cycle completion pulse
//   verify_ok       result of the last verify, held until the next start
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              verify_ok
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int SC_W  = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [SC_W-1:0]   sr_cnt_q, sr_cnt_d;        // unsent bits left in sr_q
    logic [WORD_W-1:0] hr_q, hr_d;
    logic              hr_full_q, hr_full_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  ones_sent_q, ones_sent_d;
    logic [CNT_W-1:0]  ones_read_q, ones_read_d;
    logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
    logic              verify_en_q, verify_en_d;
    logic              verify_ok_q, verify_ok_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic              handshake;
    logic              load_full;

    assign load_full  = (bit_cnt_q == CNT_W'(CHAIN_LEN));
    assign word_ready = (state_q == S_LOAD) && !hr_full_q && !load_full;
    assign handshake  = word_valid && word_ready;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        sr_cnt_d    = sr_cnt_q;
        hr_d        = hr_q;
        hr_full_d   = hr_full_q;
        bit_cnt_d   = bit_cnt_q;
        ones_sent_d = ones_sent_q;
        ones_read_d = ones_read_q;
        v_cnt_d     = v_cnt_q;
        verify_en_d = verify_en_q;
        verify_ok_d = verify_ok_q;
        head_d      = head_q;
        shift_en_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    bit_cnt_d   = '0;
                    ones_sent_d = '0;
                    ones_read_d = '0;
                    v_cnt_d     = '0;
                    verify_ok_d = 1'b0;
                    verify_en_d = verify_en;
                end
            end

            S_LOAD: begin
                if (load_full) begin
                    // The last chain bit shifts on this edge; drop any leftover bits.
                    sr_cnt_d  = '0;
                    hr_full_d = 1'b0;
                    state_d   = verify_en_q ? S_VERIFY : S_DONE;
                end else begin
                    // head_q is the bit the chain takes on the following edge, so the
                    // next bit is pulled from SR, else HR, else straight off word_in.
                    // The HR/word_in paths reload SR in the same edge: no bubble.
                    if (sr_cnt_q != '0) begin
                        head_d     = sr_q[0];
                        sr_d       = sr_q >> 1;
                        sr_cnt_d   = sr_cnt_q - SC_W'(1);
                        shift_en_d = 1'b1;
                    end else if (hr_full_q) begin
                        head_d     = hr_q[0];
                        sr_d       = hr_q >> 1;
                        sr_cnt_d   = SC_W'(WORD_W - 1);
                        hr_full_d  = 1'b0;
                        shift_en_d = 1'b1;
                    end else if (handshake) begin
                        head_d     = word_in[0];
                        sr_d       = word_in >> 1;
                        sr_cnt_d   = SC_W'(WORD_W - 1);
                        shift_en_d = 1'b1;
                    end

                    if (handshake && (sr_cnt_q != '0)) begin
                        hr_d      = word_in;
                        hr_full_d = 1'b1;
                    end

                    if (shift_en_d) begin
                        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                        ones_sent_d = ones_sent_q + CNT_W'(head_d);
                    end
                end
            end

            S_VERIFY: begin
                ones_read_d = ones_read_q + CNT_W'(ccff_tail);
                v_cnt_d     = v_cnt_q + CNT_W'(1);
                if (v_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                    verify_ok_d = (ones_read_d == ones_sent_q);
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            sr_cnt_q    <= '0;
            hr_q        <= '0;
            hr_full_q   <= 1'b0;
            bit_cnt_q   <= '0;
            ones_sent_q <= '0;
            ones_read_q <= '0;
            v_cnt_q     <= '0;
            verify_en_q <= 1'b0;
            verify_ok_q <= 1'b0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            sr_cnt_q    <= sr_cnt_d;
            hr_q        <= hr_d;
            hr_full_q   <= hr_full_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_sent_q <= ones_sent_d;
            ones_read_q <= ones_read_d;
            v_cnt_q     <= v_cnt_d;
            verify_en_q <= verify_en_d;
            verify_ok_q <= verify_ok_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
        end
    end

    // In VERIFY the chain recirculates through a combinational tail->head path.
    assign ccff_head     = (state_q == S_VERIFY) ? ccff_tail :
                           (state_q == S_LOAD)   ? head_q    : 1'b0;
    assign ccff_shift_en = (state_q == S_VERIFY) ? 1'b1 :
                           (state_q == S_LOAD)   ? shift_en_q : 1'b0;
    assign busy          = (state_q == S_LOAD) || (state_q == S_VERIFY);
    assign done          = (state_q == S_DONE);
    assign verify_ok     = verify_ok_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - self-checking bench for ccff_chain_loader
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 36;
    localparam int WORD_W    = 8;
    localparam int NW        = 5;
    localparam logic [NW*WORD_W-1:0] BASE = 40'h0F_00_FF_3C_A5;

    logic              prog_clk = 1'b0;
    logic              prog_reset_n;
    logic              start;
    logic              verify_en;
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_shift_en;
    logic              busy;
    logic              done;
    logic              verify_ok;

    logic [CHAIN_LEN-1:0] chain_q = '0;
    logic                 fault_mask;

    int tests = 0;
    int fails = 0;

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .verify_en     (verify_en),
        .word_in       (word_in),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .ccff_shift_en (ccff_shift_en),
        .busy          (busy),
        .done          (done),
        .verify_ok     (verify_ok)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: bits enter at [0] and leave at [CHAIN_LEN-1].
    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain_q <= {chain_q[CHAIN_LEN-2:0], ccff_head};
    end
    assign ccff_tail = chain_q[CHAIN_LEN-1] & ~fault_mask;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // After a full load the first streamed bit sits at the tail end of the chain.
    function automatic logic [CHAIN_LEN-1:0] chain_of(input logic [CHAIN_LEN-1:0] s);
        logic [CHAIN_LEN-1:0] r;
        for (int i = 0; i < CHAIN_LEN; i++) r[CHAIN_LEN-1-i] = s[i];
        return r;
    endfunction

    typedef struct {
        logic [NW*WORD_W-1:0] words;
        bit                   v;
        int                   gap_k;
        bit                   fault;
        bit                   poke;
        int                   exp_gaps;
        int                   exp_ones;
        bit                   exp_ok;
    } vec_t;

    vec_t vecs [5];

    logic [CHAIN_LEN-1:0] r_stream;
    logic [CHAIN_LEN-1:0] r_chain;
    int r_ld, r_vs, r_gaps, r_done_cnt, r_done_k, r_rd_ones;
    bit r_timeout, r_done_next, r_busy_next, r_ok;

    task automatic run_op(input logic [NW*WORD_W-1:0] words, input bit v, input int gap_k,
                          input bit fault, input bit poke, input int vprob);
        int  idx;
        bit  fault_done;
        bit  offer;
        idx = 0; fault_done = 0;
        r_stream = '0; r_ld = 0; r_vs = 0; r_gaps = 0; r_done_cnt = 0; r_done_k = -1;
        r_rd_ones = 0; r_timeout = 1;
        @(negedge prog_clk);
        start = 1'b1; verify_en = v; word_valid = 1'b0;
        @(posedge prog_clk);
        @(negedge prog_clk);
        for (int k = 0; k < 400; k++) begin
            start = poke && (k == 5 || k == 50);
            offer = (idx < NW) && !(idx == 2 && k < gap_k) && ($urandom_range(99) < vprob);
            word_valid = offer;
            word_in = offer ? words[idx*WORD_W +: WORD_W] : WORD_W'($urandom);
            fault_mask = fault && !fault_done && (r_ld == CHAIN_LEN) && busy && chain_q[CHAIN_LEN-1];
            if (fault_mask) fault_done = 1;
            #1;
            if (k == 0) begin
                check("first_load_ready", word_ready, 1);
                check("first_load_busy", busy, 1);
            end
            if (ccff_shift_en) begin
                if (r_ld < CHAIN_LEN) begin
                    r_stream[r_ld] = ccff_head;
                    r_ld++;
                end else begin
                    r_vs++;
                    r_rd_ones += int'(ccff_tail);
                end
            end else if (busy && r_ld > 0 && r_ld < CHAIN_LEN) begin
                r_gaps++;
            end
            if (word_valid && word_ready) idx++;
            if (done) begin
                r_done_cnt++;
                r_done_k = k;
                r_timeout = 0;
                break;
            end
            @(posedge prog_clk);
            @(negedge prog_clk);
        end
        start = 1'b0; word_valid = 1'b0; fault_mask = 1'b0;
        @(posedge prog_clk);
        @(negedge prog_clk);
        #1;
        r_done_next = done;
        r_busy_next = busy;
        r_ok        = verify_ok;
        r_chain     = chain_q;
    endtask

    task automatic check_op(input string tag, input logic [NW*WORD_W-1:0] words, input bit v,
                            input bit fault, input int exp_gaps, input int exp_ones, input bit exp_ok);
        check({tag, "_timeout"}, r_timeout, 0);
        check({tag, "_load_shifts"}, r_ld, CHAIN_LEN);
        check({tag, "_stream"}, r_stream, words[CHAIN_LEN-1:0]);
        check({tag, "_ones_sent"}, $countones(r_stream), exp_ones);
        check({tag, "_verify_shifts"}, r_vs, v ? CHAIN_LEN : 0);
        check({tag, "_done_pulses"}, r_done_cnt, 1);
        check({tag, "_done_after"}, r_done_next, 0);
        check({tag, "_busy_after"}, r_busy_next, 0);
        check({tag, "_verify_ok"}, r_ok, exp_ok);
        if (exp_gaps >= 0) begin
            check({tag, "_gaps"}, r_gaps, exp_gaps);
            check({tag, "_done_cycle"}, r_done_k, CHAIN_LEN + 1 + exp_gaps + (v ? CHAIN_LEN : 0));
        end
        if (v) check({tag, "_ones_read"}, r_rd_ones, exp_ones - int'(fault));
        if (!fault) check({tag, "_chain"}, r_chain, chain_of(words[CHAIN_LEN-1:0]));
    endtask

    initial begin
        int n;
        int idx;
        logic [NW*WORD_W-1:0] rw;
        bit rv;

        vecs[0] = '{words: BASE, v: 0, gap_k: 0,  fault: 0, poke: 0, exp_gaps: 0, exp_ones: 20, exp_ok: 0};
        vecs[1] = '{words: BASE, v: 0, gap_k: 19, fault: 0, poke: 0, exp_gaps: 3, exp_ones: 20, exp_ok: 0};
        vecs[2] = '{words: BASE, v: 1, gap_k: 0,  fault: 0, poke: 0, exp_gaps: 0, exp_ones: 20, exp_ok: 1};
        vecs[3] = '{words: BASE, v: 1, gap_k: 0,  fault: 1, poke: 0, exp_gaps: 0, exp_ones: 20, exp_ok: 0};
        vecs[4] = '{words: BASE, v: 1, gap_k: 0,  fault: 0, poke: 1, exp_gaps: 0, exp_ones: 20, exp_ok: 1};

        prog_reset_n = 1'b0; start = 1'b0; verify_en = 1'b0;
        word_valid = 1'b0; word_in = '0; fault_mask = 1'b0;
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        #1;
        check("rst_word_ready", word_ready, 0);
        check("rst_head", ccff_head, 0);
        check("rst_shift_en", ccff_shift_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_verify_ok", verify_ok, 0);
        prog_reset_n = 1'b1;

        // word_valid while idle must be ignored
        for (int i = 0; i < 4; i++) begin
            @(negedge prog_clk);
            word_valid = 1'b1; word_in = 8'hAA;
            #1;
            check("idle_ready", word_ready, 0);
            check("idle_busy", busy, 0);
            check("idle_shift_en", ccff_shift_en, 0);
        end
        word_valid = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].words, vecs[i].v, vecs[i].gap_k, vecs[i].fault, vecs[i].poke, 100);
            check_op($sformatf("vec%0d", i), vecs[i].words, vecs[i].v, vecs[i].fault,
                     vecs[i].exp_gaps, vecs[i].exp_ones, vecs[i].exp_ok);
        end

        // Reset after 20 shifts, then a clean full load
        @(negedge prog_clk);
        start = 1'b1; verify_en = 1'b1;
        @(posedge prog_clk);
        @(negedge prog_clk);
        start = 1'b0; n = 0; idx = 0;
        for (int k = 0; k < 100 && n < 20; k++) begin
            word_valid = (idx < NW);
            word_in = BASE[(idx % NW)*WORD_W +: WORD_W];
            #1;
            if (ccff_shift_en) n++;
            if (word_valid && word_ready) idx++;
            if (n < 20) begin
                @(posedge prog_clk);
                @(negedge prog_clk);
            end
        end
        check("midrst_shifts_seen", n, 20);
        prog_reset_n = 1'b0; word_valid = 1'b0;
        @(posedge prog_clk);
        @(negedge prog_clk);
        #1;
        check("midrst_shift_en", ccff_shift_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", word_ready, 0);
        check("midrst_done", done, 0);
        prog_reset_n = 1'b1;
        run_op(BASE, 0, 0, 0, 0, 100);
        check_op("after_rst", BASE, 0, 0, 0, 20, 0);

        // Randomized data, handshake pacing and verify selection
        for (int i = 0; i < 12; i++) begin
            rw = {$urandom, $urandom};
            rv = 1'($urandom_range(1));
            run_op(rw, rv, 0, 0, 0, $urandom_range(100, 40));
            check_op($sformatf("rand%0d", i), rw, rv, 0, -1, $countones(rw[CHAIN_LEN-1:0]), rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
